// File: rtl/i2c_pkg.sv
// Shared constants for the I2C core FIFOs: word widths, default depth and
// the width of the threshold fields in the register file.
package i2c_pkg;
    localparam int I2C_TXW        = 10;
    localparam int I2C_RXW        = 8;
    localparam int I2C_FIFO_DEPTH = 16;
    localparam int I2C_THR_W      = $clog2(I2C_FIFO_DEPTH) + 1;

    typedef logic [I2C_THR_W-1:0] i2c_thr_t;
endpackage

// File: rtl/i2c_thresh_fifo_if.sv
// Bus between the register file / protocol FSM (master) and the threshold
// FIFO (slave): push/pop handshake, thresholds, status and error flags.
interface i2c_thresh_fifo_if
    import i2c_pkg::*;
#(
    parameter int DW = I2C_RXW,
    parameter int AW = $clog2(I2C_FIFO_DEPTH)
);
    logic          flush;
    logic          wr;
    logic [DW-1:0] din;
    logic          rd;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
    logic [AW:0]   usedw;
    logic [AW:0]   pfull_lvl;
    logic          pfull;
    logic [AW:0]   pempty_lvl;
    logic          pempty;
    logic          ovf;
    logic          udf;
    logic          err_clr;
    logic [AW:0]   peak;

    modport master (
        output flush, wr, din, rd, pfull_lvl, pempty_lvl, err_clr,
        input  dout, full, empty, usedw, pfull, pempty, ovf, udf, peak
    );

    modport slave (
        input  flush, wr, din, rd, pfull_lvl, pempty_lvl, err_clr,
        output dout, full, empty, usedw, pfull, pempty, ovf, udf, peak
    );
endinterface

// File: rtl/i2c_fifo_ram.sv
// Simple dual-port storage array with a registered read port. A write to
// the address being read in the same cycle is forwarded (write-first).
module i2c_fifo_ram #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // The read register only loads when the head moves, so a rejected pop
    // leaves the presented word untouched.
    always_comb begin
        rdata_d = rdata_q;
        if (clr)
            rdata_d = '0;
        else if (re)
            rdata_d = (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/i2c_thresh_fifo.sv
// First-word-fall-through FIFO with programmable fill/drain thresholds,
// sync flush, sticky overflow/underflow flags and a peak-occupancy watermark.
module i2c_thresh_fifo
    import i2c_pkg::*;
#(
    parameter int DW    = I2C_RXW,
    parameter int DEPTH = I2C_FIFO_DEPTH
) (
    input logic              clk,
    input logic              rstn,
    i2c_thresh_fifo_if.slave bus
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   usedw_q, usedw_d, peak_q, peak_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          pfull_q, pfull_d, pempty_q, pempty_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic          push, pop;
    logic [DW-1:0] ram_rdata;

    always_comb begin
        push     = bus.wr && (!full_q || bus.rd) && !bus.flush;
        pop      = bus.rd && !empty_q && !bus.flush;
        wp_d     = wp_q;
        rp_d     = rp_q;
        usedw_d  = usedw_q;
        ovf_d    = ovf_q | (bus.wr && full_q && !bus.rd && !bus.flush);
        udf_d    = udf_q | (bus.rd && empty_q && !bus.flush);
        if (bus.err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (bus.flush) begin
            wp_d    = '0;
            rp_d    = '0;
            usedw_d = '0;
        end else begin
            if (push) wp_d = wp_q + CNT_ONE;
            if (pop)  rp_d = rp_q + CNT_ONE;
            if (push && !pop)
                usedw_d = usedw_q + CNT_ONE;
            else if (pop && !push)
                usedw_d = usedw_q - CNT_ONE;
        end
        // Flags come from the next-state count so they never lag usedw.
        full_d   = (usedw_d == FULL_CNT);
        empty_d  = (usedw_d == '0);
        pfull_d  = (usedw_d > bus.pfull_lvl);
        pempty_d = (usedw_d <= bus.pempty_lvl);
        peak_d   = bus.flush ? '0 : ((usedw_d > peak_q) ? usedw_d : peak_q);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wp_q     <= '0;
            rp_q     <= '0;
            usedw_q  <= '0;
            peak_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            pfull_q  <= 1'b0;
            pempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            usedw_q  <= usedw_d;
            peak_q   <= peak_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            pfull_q  <= pfull_d;
            pempty_q <= pempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // The head changes on a pop, or when a push lands in an empty FIFO.
    i2c_fifo_ram #(.DW(DW), .AW(AW)) u_ram (
        .clk   (clk),
        .clr   (!rstn || bus.flush),
        .we    (push),
        .waddr (wp_q[AW-1:0]),
        .wdata (bus.din),
        .re    (pop || (push && empty_q)),
        .raddr (rp_d[AW-1:0]),
        .rdata (ram_rdata)
    );

    assign bus.dout   = ram_rdata;
    assign bus.full   = full_q;
    assign bus.empty  = empty_q;
    assign bus.usedw  = usedw_q;
    assign bus.pfull  = pfull_q;
    assign bus.pempty = pempty_q;
    assign bus.ovf    = ovf_q;
    assign bus.udf    = udf_q;
    assign bus.peak   = peak_q;
endmodule

// File: tb/tb_i2c_thresh_fifo.sv
// Scoreboard bench for i2c_thresh_fifo: a 16x8 and a 4x10 instance driven
// against a queue-based reference model; a negedge monitor checks each cycle.
module tb_i2c_thresh_fifo;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    i2c_thresh_fifo_if #(.DW(8),  .AW(4)) ifa ();
    i2c_thresh_fifo_if #(.DW(10), .AW(2)) ifb ();

    i2c_thresh_fifo #(.DW(8),  .DEPTH(16)) dut_a (.clk(clk), .rstn(rstn), .bus(ifa));
    i2c_thresh_fifo #(.DW(10), .DEPTH(4))  dut_b (.clk(clk), .rstn(rstn), .bus(ifb));

    typedef struct {
        int         s;
        logic [9:0] dout;
        bit         dv;
        int         usedw;
        bit         full, empty, pfull, pempty, ovf, udf;
        int         peak;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   obs_max = 0;

    // reference model state
    int         depth [2] = '{16, 4};
    int         plvl  [2] = '{0, 0};
    int         elvl  [2] = '{0, 0};
    logic [9:0] mq0[$];
    logic [9:0] mq1[$];
    bit         movf  [2];
    bit         mudf  [2];
    int         mpeak [2];
    logic [9:0] mdout [2];
    bit         mdv   [2];

    function automatic void chk(string n, int s, int act, int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s dut=%0d got=%0h want=%0h at %0t", n, s, act, want, $time);
        end
    endfunction

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        for (int i = 0; i < 2; i++) begin
            movf[i] = 0; mudf[i] = 0; mpeak[i] = 0; mdout[i] = '0; mdv[i] = 1;
        end
    endtask

    task automatic model_step(input int s, input bit w, input bit r, input bit fl,
                              input bit ec, input logic [9:0] d);
        logic [9:0] q[$];
        bit push, pop;
        if (s == 0) q = mq0; else q = mq1;
        if (fl) begin
            q.delete();
            mpeak[s] = 0; mdout[s] = '0; mdv[s] = 1;
        end else begin
            push = w && ((q.size() < depth[s]) || r);
            pop  = r && (q.size() > 0);
            if (w && !push) movf[s] = 1;
            if (r && q.size() == 0) mudf[s] = 1;
            if (pop) void'(q.pop_front());
            if (push) q.push_back((s == 0) ? {2'b00, d[7:0]} : d);
            if (q.size() > mpeak[s]) mpeak[s] = q.size();
            if (q.size() > 0) begin
                mdout[s] = q[0]; mdv[s] = 1;
            end else if (pop) begin
                mdv[s] = 0;
            end
        end
        if (ec) begin movf[s] = 0; mudf[s] = 0; end
        if (s == 0) mq0 = q; else mq1 = q;
    endtask

    task automatic push_exp(input int s);
        exp_t e;
        int   sz;
        sz = (s == 0) ? mq0.size() : mq1.size();
        e.s = s; e.dout = mdout[s]; e.dv = mdv[s]; e.usedw = sz;
        e.full = (sz == depth[s]); e.empty = (sz == 0);
        e.pfull = (sz > plvl[s]); e.pempty = (sz <= elvl[s]);
        e.ovf = movf[s]; e.udf = mudf[s]; e.peak = mpeak[s];
        exp_q.push_back(e);
    endtask

    task automatic step(input int s, input bit w, input bit r, input bit fl,
                        input bit ec, input bit rs, input logic [9:0] d);
        rstn = rs;
        ifa.wr = (s == 0) && w; ifa.rd = (s == 0) && r;
        ifa.flush = (s == 0) && fl; ifa.err_clr = (s == 0) && ec;
        ifa.din = d[7:0];
        ifa.pfull_lvl = 5'(plvl[0]); ifa.pempty_lvl = 5'(elvl[0]);
        ifb.wr = (s == 1) && w; ifb.rd = (s == 1) && r;
        ifb.flush = (s == 1) && fl; ifb.err_clr = (s == 1) && ec;
        ifb.din = d;
        ifb.pfull_lvl = 3'(plvl[1]); ifb.pempty_lvl = 3'(elvl[1]);
        @(posedge clk);
        #1;
        if (!rs) model_reset();
        else model_step(s, w, r, fl, ec, d);
        push_exp(s);
    endtask

    // monitor: compare every registered output against the expected state
    exp_t       e;
    int         a_used, a_peak;
    logic [9:0] a_dout;
    bit         a_full, a_empty, a_pfull, a_pempty, a_ovf, a_udf;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.s == 0) begin
                a_dout = {2'b00, ifa.dout}; a_used = int'(ifa.usedw); a_peak = int'(ifa.peak);
                a_full = ifa.full; a_empty = ifa.empty; a_pfull = ifa.pfull;
                a_pempty = ifa.pempty; a_ovf = ifa.ovf; a_udf = ifa.udf;
            end else begin
                a_dout = ifb.dout; a_used = int'(ifb.usedw); a_peak = int'(ifb.peak);
                a_full = ifb.full; a_empty = ifb.empty; a_pfull = ifb.pfull;
                a_pempty = ifb.pempty; a_ovf = ifb.ovf; a_udf = ifb.udf;
                if (a_used > obs_max) obs_max = a_used;
            end
            chk("usedw",  e.s, a_used,       e.usedw);
            chk("full",   e.s, int'(a_full),   int'(e.full));
            chk("empty",  e.s, int'(a_empty),  int'(e.empty));
            chk("pfull",  e.s, int'(a_pfull),  int'(e.pfull));
            chk("pempty", e.s, int'(a_pempty), int'(e.pempty));
            chk("ovf",    e.s, int'(a_ovf),    int'(e.ovf));
            chk("udf",    e.s, int'(a_udf),    int'(e.udf));
            chk("peak",   e.s, a_peak,       e.peak);
            if (e.dv) chk("dout", e.s, int'(a_dout), int'(e.dout));
        end
    end

    initial begin
        int  npush, npop, cyc, sz;
        bit  w, r;
        ifa.wr = 0; ifa.rd = 0; ifa.flush = 0; ifa.err_clr = 0; ifa.din = '0;
        ifa.pfull_lvl = '0; ifa.pempty_lvl = '0;
        ifb.wr = 0; ifb.rd = 0; ifb.flush = 0; ifb.err_clr = 0; ifb.din = '0;
        ifb.pfull_lvl = '0; ifb.pempty_lvl = '0;
        plvl[0] = 3; elvl[0] = 2;

        // reset, then fill 0x00..0x0F, overflow, drain in order, underflow
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0, 1, 10'(i));
        step(0, 1, 0, 0, 0, 1, 10'h77);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0);

        // simultaneous rd/wr on empty, then on full
        step(0, 1, 1, 0, 0, 1, 10'h0A5);
        step(0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 0, 1, 10'(8'h30 + i));
        step(0, 1, 1, 0, 0, 1, 10'h099);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0, 1, 0);

        // flush together with a write after 9 entries
        for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 0, 1, 10'(8'h60 + i));
        step(0, 1, 0, 1, 0, 1, 10'h055);
        step(0, 1, 0, 0, 0, 1, 10'h0C3);
        step(0, 0, 1, 0, 0, 1, 0);

        // reset in the middle of a write burst
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 1, 10'(8'h80 + i));
        step(0, 1, 0, 0, 0, 0, 10'h0EE);
        step(0, 0, 0, 0, 0, 1, 0);

        // err_clr wins over an overflow in the same cycle
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0, 1, 10'(8'h90 + i));
        step(0, 1, 0, 0, 1, 1, 10'h011);
        step(0, 1, 0, 0, 0, 1, 10'h022);
        step(0, 0, 0, 0, 1, 1, 0);

        // random interleaved traffic on the 4-deep, 10-bit instance
        npush = 0; npop = 0; cyc = 0;
        obs_max = 0;
        while ((npush < 40 || npop < 40) && cyc < 2000) begin
            w = (npush < 40) && ($urandom_range(0, 2) != 0);
            r = (npop < 40) && ($urandom_range(0, 2) != 0);
            plvl[1] = $urandom_range(0, 4);
            elvl[1] = $urandom_range(0, 4);
            sz = mq1.size();
            if (w && (sz < 4 || r)) npush++;
            if (r && sz > 0) npop++;
            step(1, w, r, 0, 0, 1, 10'($urandom));
            cyc++;
        end
        step(1, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        #1;
        chk("rand_done", 1, int'(npush >= 40 && npop >= 40), 1);
        chk("peak_obs",  1, int'(ifb.peak), obs_max);
        chk("peak_le4",  1, int'(ifb.peak <= 3'd4), 1);
        chk("sb_drain",  1, exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_thresh_fifo.md
# i2c_thresh_fifo

Parametrised synchronous FIFO that replaces the fixed 16-deep TX/RX buffers of the I2C core. Adds programmable fill and drain thresholds, a synchronous flush, sticky overflow and underflow flags, and a peak-occupancy watermark. One instance sits between the register file and the I2C protocol FSM on each direction: TX holds 10-bit command+data words, RX holds 8-bit data. Read data is first-word-fall-through.

## Interface
Parameters:
- `DW`, 8: data width in bits (TX instance uses 10).
- `DEPTH`, 16: number of entries; power of two, ≥2.
- `AW`, $clog2(DEPTH): pointer width; derived, never overridden.

Ports:
- `clk` in 1: single clock.
- `rstn` in 1: synchronous, active-low reset.
- `flush` in 1: synchronous clear of contents, pointers and watermark.
- `wr` in 1: push `din`.
- `din` in DW: write data.
- `full` out 1: `usedw == DEPTH`.
- `rd` in 1: pop the current head.
- `dout` out DW: head entry; valid whenever `!empty`.
- `empty` out 1: `usedw == 0`.
- `usedw` out AW+1: occupancy, 0..DEPTH.
- `pfull_lvl` in AW+1: fill threshold.
- `pfull` out 1: `usedw > pfull_lvl`.
- `pempty_lvl` in AW+1: drain threshold.
- `pempty` out 1: `usedw <= pempty_lvl`.
- `ovf` out 1: sticky; set by a write while full.
- `udf` out 1: sticky; set by a read while empty.
- `err_clr` in 1: clears `ovf` and `udf`.
- `peak` out AW+1: highest `usedw` seen since the last reset or flush.

## Operation
- Storage: DEPTH×DW array. Write pointer `wp` and read pointer `rp` are AW+1 bits, and the MSB distinguishes full from empty. Pointers wrap modulo 2·DEPTH, with no special case at the wrap.
- Push accepted: `wr && (!full || rd)`. Pop accepted: `rd && !empty`.
- Full with `rd` and `wr` in the same cycle: both are accepted, `usedw` is unchanged and `ovf` is not set.
- Empty with `rd` and `wr` in the same cycle: the write is accepted, the read is ignored and `udf` is set.
- Rejected write: data is dropped, `ovf` is set, no state changes. Rejected read: `dout` is unchanged, `udf` is set.
- `usedw` is a registered counter: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- `pfull`, `pempty`, `full` and `empty` are registered and derived from the next-state `usedw`, so they are consistent with `usedw` in every cycle.
- Threshold levels are sampled every cycle. A change takes effect on the flags in the cycle after it.
- `peak` updates to next `usedw` when that value exceeds the current `peak`.
- Priority each cycle: `!rstn` > `flush` > push/pop. `flush` also discards any `wr` or `rd` in the same cycle. `flush` does not clear `ovf` or `udf`.
- `err_clr` takes priority over a set in the same cycle, so the flag stays 0.
- Reset values: `usedw`=0, `empty`=1, `full`=0, `pfull`=0, `pempty`=1, `ovf`=0, `udf`=0, `peak`=0, `dout`=0. Array contents are not reset.
- After `flush`, all outputs hold their reset values except `ovf` and `udf`.

## Timing
- Write-to-read latency: a push at edge N into an empty FIFO gives `empty`=0 and valid `dout` after edge N.
- Pop: at the edge where `rd` is accepted, `dout` advances to the next entry, which is visible in the following cycle. There is no bubble under back-to-back reads.
- Sustained throughput is one push and one pop per cycle.
- Every output is registered. No combinational path exists from an input to an output.
- Reset or flush asserted mid-burst: the FIFO is empty from the next cycle, and in-flight data is lost.

## Structure
- `i2c_pkg` holds:
  - `I2C_TXW`=10 and `I2C_RXW`=8;
  - the default depth constant;
  - the threshold field width used by the register file.
- Sub-module `i2c_fifo_ram` is a simple dual-port array with a registered read port and a write-first bypass. `i2c_thresh_fifo` owns pointers, counters, flags and the FWFT output stage.

## Test plan
- DEPTH=16, DW=8: write 0x00..0x0F → `full`=1 and `usedw`=16. A 17th write sets `ovf`=1 and content is unchanged. Reading 16 times returns 0x00..0x0F in order, then `empty`=1.
- Empty FIFO, `rd` with `wr` of 0xA5 in the same cycle → `udf`=1, `usedw`=1, `dout`=0xA5 next cycle. Full FIFO, `rd` with `wr` → `usedw` stays 16 and `ovf`=0.
- `pfull_lvl`=3 → `pfull` rises in the cycle after the 4th write. `pempty_lvl`=2 → `pempty` reasserts in the cycle after `usedw` drops to 2.
- Interleaved traffic, 40 pushes and 40 pops, with random gaps at DEPTH=4 and DW=10 → order preserved across pointer wrap, `peak` ≤ 4 and equal to the observed maximum.
- Fill 9 entries, then assert `flush` in the same cycle as `wr` → next cycle `usedw`=0, `peak`=0 and `empty`=1.
- Mid-burst reset → reset values next cycle.
- `err_clr` in the same cycle as an overflow write → `ovf` stays 0.
